// File: rtl/shift_pipe_if.sv
// Request/result handshake bundle for shift_pipe.
// master = producer/consumer side, slave = the shift unit.
interface shift_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_mode;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [TAG_W-1:0]   out_tag;
  logic               out_zero;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_zero
  );
endinterface

// File: rtl/shift_pipe.sv
// Pipelined SLL/SRL/SRA/ROL unit; the log-shifter levels are interleaved
// across DEPTH register stages, with a valid/ready handshake and global stall.
module shift_pipe #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int DEPTH   = 2,
  parameter int TAG_W   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  shift_pipe_if.slave  bus
);

  // Shift amount and mode only need to travel to stages that still shift.
  localparam int CARRY_N = (DEPTH > 1) ? DEPTH - 1 : 1;

  logic [DEPTH-1:0]                r_valid;
  logic [DEPTH-1:0][WIDTH-1:0]     r_data;
  logic [DEPTH-1:0][TAG_W-1:0]     r_tag;
  logic [CARRY_N-1:0][SHAMT_W-1:0] r_shamt;
  logic [CARRY_N-1:0][1:0]         r_mode;
  logic                            r_zero;

  logic [DEPTH-1:0]                w_load;
  logic [DEPTH-1:0]                w_src_valid;
  logic [DEPTH-1:0][WIDTH-1:0]     w_src_data;
  logic [DEPTH-1:0][WIDTH-1:0]     w_next_data;
  logic [DEPTH-1:0][TAG_W-1:0]     w_src_tag;
  logic [DEPTH-1:0][SHAMT_W-1:0]   w_src_shamt;
  logic [DEPTH-1:0][1:0]           w_src_mode;

  // Stage `stage` applies the shift-amount bits b with b % DEPTH == stage.
  function automatic logic [WIDTH-1:0] f_shift_stage(
    input logic [WIDTH-1:0]   d,
    input logic [1:0]         mode,
    input logic [SHAMT_W-1:0] shamt,
    input int                 stage
  );
    logic [WIDTH-1:0] v;
    int               amt;
    v = d;
    for (int b = 0; b < SHAMT_W; b++) begin
      amt = 32'sd1 << b;
      if (((b % DEPTH) == stage) && shamt[b]) begin
        case (mode)
          2'b00:   v = v << amt;
          2'b01:   v = v >> amt;
          2'b10:   v = $signed(v) >>> amt;
          2'b11:   v = (v << amt) | (v >> (WIDTH - amt));
          default: v = v;
        endcase
      end else begin
        v = v;
      end
    end
    return v;
  endfunction

  // Per-stage source selection and partial shift.
  always_comb begin
    w_src_valid = '0;
    w_src_data  = '0;
    w_src_tag   = '0;
    w_src_shamt = '0;
    w_src_mode  = '0;
    w_next_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k == 0) begin
        w_src_valid[k] = bus.in_valid;
        w_src_data[k]  = bus.in_data;
        w_src_tag[k]   = bus.in_tag;
        w_src_shamt[k] = bus.in_shamt;
        w_src_mode[k]  = bus.in_mode;
      end else begin
        w_src_valid[k] = r_valid[k-1];
        w_src_data[k]  = r_data[k-1];
        w_src_tag[k]   = r_tag[k-1];
        w_src_shamt[k] = r_shamt[k-1];
        w_src_mode[k]  = r_mode[k-1];
      end
      w_next_data[k] = f_shift_stage(w_src_data[k], w_src_mode[k], w_src_shamt[k], k);
    end
  end

  // A stage loads if any stage from it to the output is empty, or the consumer takes.
  always_comb begin
    logic w_space;
    w_load = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_space = bus.out_ready;
      for (int j = k; j < DEPTH; j++) begin
        if (!r_valid[j]) begin
          w_space = 1'b1;
        end else begin
          w_space = w_space;
        end
      end
      w_load[k] = enable && w_space;
    end
  end

  // Stage registers; data only captures valid entries so idle outputs hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_data  <= '0;
      r_tag   <= '0;
      r_shamt <= '0;
      r_mode  <= '0;
      r_zero  <= 1'b1;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_load[k]) begin
          r_valid[k] <= w_src_valid[k];
          if (w_src_valid[k]) begin
            r_data[k] <= w_next_data[k];
            r_tag[k]  <= w_src_tag[k];
            if (k < DEPTH - 1) begin
              r_shamt[k] <= w_src_shamt[k];
              r_mode[k]  <= w_src_mode[k];
            end
          end
        end
      end
      if (w_load[DEPTH-1] && w_src_valid[DEPTH-1]) begin
        r_zero <= (w_next_data[DEPTH-1] == '0);
      end
    end
  end

  assign bus.in_ready  = rst_n && w_load[0];
  assign bus.out_valid = r_valid[DEPTH-1];
  assign bus.out_data  = r_data[DEPTH-1];
  assign bus.out_tag   = r_tag[DEPTH-1];
  assign bus.out_zero  = r_zero;

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed vectors plus a randomized
// stream checked against a bit-index reference model and a FIFO scoreboard.
module tb_shift_pipe;
  localparam int W  = 32;
  localparam int SW = $clog2(W);
  localparam int D  = 2;
  localparam int TW = 4;

  typedef struct {
    logic [W-1:0]  data;
    logic [TW-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  always #5 clk = ~clk;

  shift_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();
  shift_pipe #(.WIDTH(W), .DEPTH(D), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus)
  );

  exp_t          q[$];
  int            checks = 0;
  int            errors = 0;
  logic          prev_ok = 1'b0;
  logic          prev_valid, prev_emit, prev_zero;
  logic [W-1:0]  prev_data;
  logic [TW-1:0] prev_tag;

  // Result bit i is taken from source bit position derived from the mode rule.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [1:0] m, input int s);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      case (m)
        2'd0: r[i] = (i - s >= 0) ? d[(i - s >= 0) ? i - s : 0] : 1'b0;
        2'd1: r[i] = (i + s < W) ? d[(i + s < W) ? i + s : 0] : 1'b0;
        2'd2: r[i] = (i + s < W) ? d[(i + s < W) ? i + s : 0] : d[W-1];
        default: r[i] = d[(i - s + W) % W];
      endcase
    end
    return r;
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] d, input logic [SW-1:0] s,
                       input logic [1:0] m, input logic [TW-1:0] t);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_shamt = s;
    bus.in_mode  = m;
    bus.in_tag   = t;
  endtask

  // One clock: scoreboard bookkeeping at negedge+1, then advance to next negedge.
  task automatic cycle();
    exp_t e;
    logic exp_rdy, emit;
    #1;
    exp_rdy = rst_n && enable && ((q.size() < D) || bus.out_ready);
    checks++;
    if (bus.in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL in_ready t=%0t got %b expected %b", $time, bus.in_ready, exp_rdy);
    end
    if (prev_ok && prev_valid && !prev_emit) begin
      checks++;
      if ({bus.out_valid, bus.out_data, bus.out_tag, bus.out_zero} !== {1'b1, prev_data, prev_tag, prev_zero}) begin
        errors++;
        $display("FAIL stall_hold t=%0t got v%b %h/%h/%b expected v1 %h/%h/%b", $time, bus.out_valid,
                 bus.out_data, bus.out_tag, bus.out_zero, prev_data, prev_tag, prev_zero);
      end
    end else if (prev_ok && !prev_valid && !bus.out_valid) begin
      checks++;
      if (bus.out_data !== prev_data) begin
        errors++;
        $display("FAIL idle_hold t=%0t got %h expected %h", $time, bus.out_data, prev_data);
      end
    end
    emit = rst_n && enable && bus.out_valid && bus.out_ready;
    if (emit) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL spurious_out t=%0t got tag %h expected no result", $time, bus.out_tag);
      end else begin
        e = q.pop_front();
        if (bus.out_data !== e.data || bus.out_tag !== e.tag || bus.out_zero !== (e.data == '0)) begin
          errors++;
          $display("FAIL result t=%0t got %h/%h/%b expected %h/%h/%b", $time, bus.out_data, bus.out_tag,
                   bus.out_zero, e.data, e.tag, (e.data == '0));
        end
      end
    end
    if (rst_n && bus.in_valid && bus.in_ready) begin
      e.data = ref_shift(bus.in_data, bus.in_mode, int'(bus.in_shamt));
      e.tag  = bus.in_tag;
      q.push_back(e);
    end
    prev_ok    = rst_n;
    prev_valid = bus.out_valid;
    prev_emit  = emit;
    prev_data  = bus.out_data;
    prev_tag   = bus.out_tag;
    prev_zero  = bus.out_zero;
    @(posedge clk);
    @(negedge clk);
    if (!rst_n) begin
      q.delete();
      prev_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; bus.out_ready = 1'b1;
    drive(1'b0, '0, '0, 2'd0, '0);
    cycle();
    cycle();
    checks++;
    if ({bus.out_valid, bus.out_data, bus.out_tag, bus.out_zero, bus.in_ready} !== {1'b0, {W{1'b0}}, {TW{1'b0}}, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got v%b d%h t%h z%b r%b expected v0 d0 t0 z1 r0", bus.out_valid,
               bus.out_data, bus.out_tag, bus.out_zero, bus.in_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0]  vd[4] = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'h8000_0001};
    logic [SW-1:0] vs[4] = '{5'd2, 5'd4, 5'd4, 5'd1};
    logic [W-1:0]  ve[4] = '{32'h0000_0004, 32'h0800_0000, 32'hF800_0000, 32'h0000_0003};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vd[i], vs[i], 2'(i), 4'(i + 1));
      cycle();
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL latency_early v%0d got out_valid %b expected 0", i, bus.out_valid);
      end
      drive(1'b0, '0, '0, 2'd0, '0);
      cycle();
      checks++;
      if ({bus.out_valid, bus.out_data, bus.out_tag} !== {1'b1, ve[i], 4'(i + 1)}) begin
        errors++;
        $display("FAIL directed v%0d got v%b %h tag %h expected v1 %h tag %h", i, bus.out_valid,
                 bus.out_data, bus.out_tag, ve[i], 4'(i + 1));
      end
      cycle();
    end
  endtask

  task automatic test_boundaries();
    logic [W-1:0]  vd[8] = '{32'hA5C3_0F96, 32'hA5C3_0F96, 32'hA5C3_0F96, 32'hA5C3_0F96,
                             32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h8000_0000};
    logic [SW-1:0] vs[8] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd31, 5'd31, 5'd1};
    logic [1:0]    vm[8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd0};
    logic [W-1:0]  ve[8] = '{32'hA5C3_0F96, 32'hA5C3_0F96, 32'hA5C3_0F96, 32'hA5C3_0F96,
                             32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vd[i], vs[i], vm[i], 4'(i));
      cycle();
      drive(1'b0, '0, '0, 2'd0, '0);
      cycle();
      checks++;
      if ({bus.out_valid, bus.out_data, bus.out_zero} !== {1'b1, ve[i], (i == 7)}) begin
        errors++;
        $display("FAIL boundary b%0d got v%b %h z%b expected v1 %h z%b", i, bus.out_valid,
                 bus.out_data, bus.out_zero, ve[i], (i == 7));
      end
      cycle();
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      drive(j < 8, $urandom(), SW'($urandom_range(0, W - 1)), 2'($urandom_range(0, 3)), 4'(j));
      cycle();
      checks++;
      if (bus.out_valid !== (j >= 1 && j <= 8) || (bus.out_valid && bus.out_tag !== 4'(j - 1))) begin
        errors++;
        $display("FAIL back_to_back c%0d got v%b tag %h expected v%b tag %h", j, bus.out_valid,
                 bus.out_tag, (j >= 1 && j <= 8), 4'(j - 1));
      end
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, $urandom(), SW'($urandom_range(0, W - 1)), 2'($urandom_range(0, 3)), 4'(k));
      #1;
      checks++;
      if (bus.in_ready !== (k < 2)) begin
        errors++;
        $display("FAIL bp_ready k%0d got %b expected %b", k, bus.in_ready, (k < 2));
      end
      cycle();
    end
    drive(1'b0, '0, '0, 2'd0, '0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8 && q.size() != 0; k++) begin
      if (bus.out_valid) begin
        checks++;
        if (bus.out_tag !== 4'(n)) begin
          errors++;
          $display("FAIL bp_order got tag %h expected %h", bus.out_tag, 4'(n));
        end
        n++;
      end
      cycle();
    end
    checks++;
    if (n != 2 || q.size() != 0) begin
      errors++;
      $display("FAIL bp_drain got %0d results, %0d left expected 2, 0", n, q.size());
    end
  endtask

  task automatic test_enable();
    logic [W-1:0]  sd;
    logic [TW-1:0] st;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, $urandom(), SW'($urandom_range(1, W - 1)), 2'($urandom_range(0, 3)), 4'(10 + k));
      cycle();
    end
    sd = bus.out_data;
    st = bus.out_tag;
    enable = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, $urandom(), 5'd3, 2'd0, 4'd12);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.out_tag, bus.out_data} !== {1'b0, 1'b1, st, sd}) begin
        errors++;
        $display("FAIL enable_freeze k%0d got r%b v%b %h/%h expected r0 v1 %h/%h", k, bus.in_ready,
                 bus.out_valid, bus.out_tag, bus.out_data, st, sd);
      end
      cycle();
    end
    enable = 1'b1;
    drive(1'b0, '0, '0, 2'd0, '0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.out_valid !== (k < 2) || (k < 2 && bus.out_tag !== 4'(10 + k))) begin
        errors++;
        $display("FAIL enable_resume k%0d got v%b tag %h expected v%b tag %h", k, bus.out_valid,
                 bus.out_tag, (k < 2), 4'(10 + k));
      end
      cycle();
    end
  endtask

  task automatic test_reset_midflight();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'hFFFF_0000, 5'd4, 2'd2, 4'(5 + k));
      cycle();
    end
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 2'd0, '0);
    cycle();
    checks++;
    if ({bus.out_valid, bus.out_zero, bus.out_data, bus.out_tag, bus.in_ready} !== {1'b0, 1'b1, {W{1'b0}}, {TW{1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL midflight_reset got v%b z%b %h/%h r%b expected v0 z1 0/0 r0", bus.out_valid,
               bus.out_zero, bus.out_data, bus.out_tag, bus.in_ready);
    end
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_result k%0d got out_valid %b tag %h expected 0", k, bus.out_valid, bus.out_tag);
      end
      cycle();
    end
    drive(1'b1, 32'h0000_0003, 5'd1, 2'd0, 4'd7);
    cycle();
    drive(1'b0, '0, '0, 2'd0, '0);
    cycle();
    checks++;
    if ({bus.out_valid, bus.out_tag, bus.out_data} !== {1'b1, 4'd7, 32'h0000_0006}) begin
      errors++;
      $display("FAIL after_reset got v%b %h/%h expected v1 7/00000006", bus.out_valid, bus.out_tag, bus.out_data);
    end
    cycle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      enable        = ($urandom_range(0, 9) != 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      drive($urandom_range(0, 9) < 7, $urandom(), SW'($urandom_range(0, W - 1)),
            2'($urandom_range(0, 3)), TW'($urandom()));
      cycle();
    end
    enable = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b0, '0, '0, 2'd0, '0);
    for (int k = 0; k < 10 && q.size() != 0; k++) begin
      cycle();
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL random_drain got %0d outstanding expected 0", q.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    enable = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b0, '0, '0, 2'd0, '0);
    @(negedge clk);
    test_reset();
    test_directed();
    test_boundaries();
    test_back_to_back();
    test_backpressure();
    test_enable();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
